// File: rtl/wb_write_queue.sv
// ============================================================================
// Module      : wb_write_queue
// Description : In-order writeback FIFO feeding the register file write port,
//               with youngest-first forwarding of pending writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        fwd_addr1,
  input  logic [ADDR_W-1:0]        fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w+1)'(DEPTH);
  localparam logic [c_ptr_w:0]  c_one   = (c_ptr_w+1)'(1);
  localparam logic [c_ptr_w:0]  c_two   = (c_ptr_w+1)'(2);

  logic [ADDR_W-1:0]  r_addr_q [DEPTH];
  logic [DATA_W-1:0]  r_data_q [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_rf_we;
  logic [ADDR_W-1:0]  r_rf_waddr;
  logic [DATA_W-1:0]  r_rf_wdata;

  logic [c_ptr_w:0]   w_free;
  logic               w_mem_push;
  logic               w_alu_push;
  logic               w_pop;
  logic [c_ptr_w-1:0] w_alu_slot;

  // Ready looks only at the registered count, so a load always gets the last slot.
  assign w_free     = c_depth - r_count;
  assign mem_ready  = (w_free >= c_one);
  assign alu_ready  = (w_free >= c_two) || ((w_free == c_one) && !mem_valid);

  // Register 0 results complete the handshake but are dropped here.
  assign w_mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_wptr + c_ptr_w'(w_mem_push);

  assign count      = r_count;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_addr_q[r_wptr] <= mem_rd;
      r_data_q[r_wptr] <= mem_data;
    end
    if (w_alu_push) begin
      r_addr_q[w_alu_slot] <= alu_rd;
      r_data_q[w_alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_wptr  <= r_wptr + c_ptr_w'(w_mem_push) + c_ptr_w'(w_alu_push);
      r_rptr  <= r_rptr + c_ptr_w'(w_pop);
      r_count <= r_count + (c_ptr_w+1)'(w_mem_push) + (c_ptr_w+1)'(w_alu_push)
                 - (c_ptr_w+1)'(w_pop);
      r_rf_we <= w_pop;
      if (w_pop) begin
        r_rf_waddr <= r_addr_q[r_rptr];
        r_rf_wdata <= r_data_q[r_rptr];
      end
    end
  end

  // Scan oldest to youngest (rf stage, then head to tail) so the last match wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic               hit;
    logic [DATA_W-1:0]  d;
    logic [c_ptr_w-1:0] slot;
    hit = r_rf_we && (r_rf_waddr == a);
    d   = hit ? r_rf_wdata : '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = r_rptr + c_ptr_w'(i);
      if (((c_ptr_w+1)'(i) < r_count) && (r_addr_q[slot] == a)) begin
        hit = 1'b1;
        d   = r_data_q[slot];
      end
    end
    if (a == '0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_addr1);
    {fwd_hit2, fwd_data2} = lookup(fwd_addr2);
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_write_queue.sv
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Directed self-checking bench for wb_write_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_write_queue;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_addr1;
  logic [4:0]  fwd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  int errors;
  int checks;

  wb_write_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fwd_addr1 (fwd_addr1),
    .fwd_addr2 (fwd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    fwd_addr1 = 5'd5; fwd_addr2 = 5'd7;

    // Reset and release
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_hit1", 32'(fwd_hit1), 32'd0);
    check("rst_data1", fwd_data1, 32'd0);

    // Single ALU write rd=5, 0xAA
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    #1;
    check("t2_pre_hit", 32'(fwd_hit1), 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("t2_n_count", 32'(count), 32'd1);
    check("t2_n_we", 32'(rf_we), 32'd0);
    check("t2_n_hit", 32'(fwd_hit1), 32'd1);
    check("t2_n_data", fwd_data1, 32'hAA);
    tick(); #1;
    check("t2_n1_we", 32'(rf_we), 32'd1);
    check("t2_n1_waddr", 32'(rf_waddr), 32'd5);
    check("t2_n1_wdata", rf_wdata, 32'hAA);
    check("t2_n1_count", 32'(count), 32'd0);
    check("t2_n1_hit", 32'(fwd_hit1), 32'd1);
    check("t2_n1_data", fwd_data1, 32'hAA);
    check("t2_miss2", 32'(fwd_hit2), 32'd0);
    tick(); #1;
    check("t2_n2_we", 32'(rf_we), 32'd0);
    check("t2_n2_hold_addr", 32'(rf_waddr), 32'd5);
    check("t2_n2_hold_data", rf_wdata, 32'hAA);
    check("t2_n2_hit", 32'(fwd_hit1), 32'd0);
    check("t2_n2_data", fwd_data1, 32'd0);

    // Simultaneous mem/ALU to the same register
    fwd_addr1 = 5'd3;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
    #1;
    check("t3_mem_ready", 32'(mem_ready), 32'd1);
    check("t3_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    check("t3_n_count", 32'(count), 32'd2);
    check("t3_n_fwd", fwd_data1, 32'h22);
    tick(); #1;
    check("t3_w1_we", 32'(rf_we), 32'd1);
    check("t3_w1_data", rf_wdata, 32'h11);
    check("t3_w1_fwd", fwd_data1, 32'h22);
    tick(); #1;
    check("t3_w2_we", 32'(rf_we), 32'd1);
    check("t3_w2_data", rf_wdata, 32'h22);
    check("t3_w2_fwd", fwd_data1, 32'h22);
    check("t3_w2_count", 32'(count), 32'd0);
    tick(); #1;
    check("t3_end_we", 32'(rf_we), 32'd0);
    check("t3_end_hit", 32'(fwd_hit1), 32'd0);

    // Two pushes per cycle against one pop per cycle
    fwd_addr1 = 5'd7;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h101;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h202;
    tick();
    mem_rd = 5'd3; mem_data = 32'h303;
    alu_rd = 5'd4; alu_data = 32'h404;
    #1;
    check("t4_e1_count", 32'(count), 32'd2);
    check("t4_e1_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    mem_rd = 5'd6; mem_data = 32'h606;
    alu_rd = 5'd7; alu_data = 32'h707;
    #1;
    check("t4_e2_count", 32'(count), 32'd3);
    check("t4_e2_wdata", rf_wdata, 32'h101);
    check("t4_e2_mem_ready", 32'(mem_ready), 32'd1);
    check("t4_e2_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    mem_valid = 1'b0;
    #1;
    check("t4_e3_count", 32'(count), 32'd3);
    check("t4_e3_wdata", rf_wdata, 32'h202);
    check("t4_e3_alu_ready", 32'(alu_ready), 32'd1);
    check("t4_e3_hit_pending", 32'(fwd_hit1), 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("t4_e4_count", 32'(count), 32'd3);
    check("t4_e4_wdata", rf_wdata, 32'h303);
    check("t4_e4_fwd7", fwd_data1, 32'h707);
    tick(); #1;
    check("t4_e5_wdata", rf_wdata, 32'h404);
    tick(); #1;
    check("t4_e6_wdata", rf_wdata, 32'h606);
    tick(); #1;
    check("t4_e7_wdata", rf_wdata, 32'h707);
    check("t4_e7_count", 32'(count), 32'd0);
    tick(); #1;
    check("t4_e8_we", 32'(rf_we), 32'd0);

    // Register 0 pushes
    fwd_addr1 = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBEEF;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    #1;
    check("t5_mem_ready", 32'(mem_ready), 32'd1);
    check("t5_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    check("t5_count", 32'(count), 32'd0);
    check("t5_hit0", 32'(fwd_hit1), 32'd0);
    tick(); #1;
    check("t5_we", 32'(rf_we), 32'd0);

    // Reset with three entries queued
    fwd_addr1 = 5'd10; fwd_addr2 = 5'd12;
    mem_valid = 1'b1; mem_rd = 5'd9;  mem_data = 32'h909;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A;
    tick();
    mem_rd = 5'd11; mem_data = 32'hB0B;
    alu_rd = 5'd12; alu_data = 32'hC0C;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    check("t6_pre_count", 32'(count), 32'd3);
    check("t6_pre_we", 32'(rf_we), 32'd1);
    check("t6_pre_fwd2", fwd_data2, 32'hC0C);
    reset = 1'b0;
    #1;
    check("t6_rst_we", 32'(rf_we), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_hit1", 32'(fwd_hit1), 32'd0);
    check("t6_rst_hit2", 32'(fwd_hit2), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("t6_post_we", 32'(rf_we), 32'd0);
      check("t6_post_count", 32'(count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
